// File: rtl/portout.sv
// Serial port transmitter: accepts one parallel packet via vld/granted and
// drives it onto frame_n/valid_n/dout, address then payload, both LSB-first.
module portout #(
    parameter int AW  = 4,
    parameter int PW  = 32,
    parameter int GAP = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          vld,
    input  logic [AW-1:0] addr,
    input  logic [PW-1:0] payload,
    output logic          granted,
    output logic          frame_n,
    output logic          valid_n,
    output logic          dout,
    output logic          busy,
    output logic          done
);

    localparam int MAXW = (AW > PW) ? AW : PW;
    localparam int MAXC = (MAXW > GAP) ? MAXW : GAP;
    localparam int CW0  = $clog2(MAXC) + 1;
    localparam int CW   = (CW0 < 6) ? 6 : CW0;

    typedef enum logic [1:0] {IDLE, ADDR, PAY, GAPW} state_t;

    state_t        state;
    logic [AW-1:0] addr_sr;
    logic [PW-1:0] pay_sr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_sr <= '0;
            pay_sr  <= '0;
            cnt     <= '0;
            granted <= 1'b0;
            frame_n <= 1'b1;
            valid_n <= 1'b1;
            dout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            granted <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (vld) begin
                        // addr[0] goes straight to the wire, so the shifter keeps only the rest
                        addr_sr <= addr >> 1;
                        pay_sr  <= payload;
                        dout    <= addr[0];
                        frame_n <= 1'b0;
                        valid_n <= 1'b1;
                        granted <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt == CW'(AW - 1)) begin
                        dout    <= pay_sr[0];
                        pay_sr  <= pay_sr >> 1;
                        valid_n <= 1'b0;
                        cnt     <= '0;
                        state   <= PAY;
                    end else begin
                        dout    <= addr_sr[0];
                        addr_sr <= addr_sr >> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                PAY: begin
                    // frame_n high inside PAY means the end-of-frame bit is on the wire
                    if (frame_n) begin
                        valid_n <= 1'b1;
                        dout    <= 1'b0;
                        cnt     <= '0;
                        if (GAP > 1) begin
                            state <= GAPW;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        dout   <= pay_sr[0];
                        pay_sr <= pay_sr >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(PW - 2)) begin
                            frame_n <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                GAPW: begin
                    if (cnt == CW'(GAP - 2)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
